// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending transaction controller: coin and change
// encodings, sequencer states, default sizing, and the coin-to-credit helper.
// Credit is always counted in 5-unit steps.
// ---------------------------------------------------------------------------
package vend_pkg;

    localparam int VEND_NUM_ITEMS  = 4;
    localparam int VEND_CREDIT_W   = 5;
    localparam int VEND_STOCK_W    = 4;
    localparam int VEND_STOCK_INIT = 8;
    localparam int VEND_DEF_PRICE  = 3;
    localparam int VEND_TIMEOUT    = 64;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10,
        COIN_BAD  = 2'b11
    } coin_e;

    typedef enum logic [1:0] {
        CHG_NONE = 2'b00,
        CHG_5    = 2'b01,
        CHG_10   = 2'b10
    } change_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_CREDIT   = 2'b01,
        ST_DISPENSE = 2'b10,
        ST_CHANGE   = 2'b11
    } state_e;

    // Credit value of a coin code in steps; invalid or absent coins are worth 0.
    function automatic logic [1:0] coin_steps(input logic [1:0] code);
        logic [1:0] steps;
        case (code)
            COIN_5:  steps = 2'd1;
            COIN_10: steps = 2'd2;
            default: steps = 2'd0;
        endcase
        return steps;
    endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// ---------------------------------------------------------------------------
// vend_sequencer_if
// Bundles every sequencer signal except clk/rst.
//   master : coin/keypad front end, config agent and dispenser side
//            (drives coin, sel_*, cancel, cfg_*, restock, disp_done)
//   slave  : vend_sequencer (drives disp_req/idx, change, credit, busy and
//            the one-cycle status pulses)
// ---------------------------------------------------------------------------
interface vend_sequencer_if
    import vend_pkg::*;
#(
    parameter int CREDIT_W = VEND_CREDIT_W,
    parameter int IDX_W    = 2
);
    logic [1:0]          coin;
    logic                sel_valid;
    logic [IDX_W-1:0]    sel_idx;
    logic                cancel;
    logic                cfg_we;
    logic                restock;
    logic [IDX_W-1:0]    cfg_idx;
    logic [CREDIT_W-1:0] cfg_price;
    logic                disp_req;
    logic [IDX_W-1:0]    disp_idx;
    logic                disp_done;
    logic [1:0]          change;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                coin_reject;
    logic                sold_out;
    logic                short_pay;

    modport master (
        output coin, sel_valid, sel_idx, cancel, cfg_we, restock,
               cfg_idx, cfg_price, disp_done,
        input  disp_req, disp_idx, change, credit, busy,
               coin_reject, sold_out, short_pay
    );

    modport slave (
        input  coin, sel_valid, sel_idx, cancel, cfg_we, restock,
               cfg_idx, cfg_price, disp_done,
        output disp_req, disp_idx, change, credit, busy,
               coin_reject, sold_out, short_pay
    );

endinterface

// File: rtl/vend_slot_table.sv
// ---------------------------------------------------------------------------
// vend_slot_table
// Per-slot price and stock register file.
//   clk, rst              : clock, synchronous active-high reset
//   rd_idx -> rd_price/rd_stock : combinational read port
//   dec_en, dec_idx       : take one item from a slot (saturates at 0)
//   cfg_en                : gate for cfg_we/restock (sequencer idle)
//   cfg_we, cfg_idx, cfg_price : price write; a price of 0 is ignored
//   restock               : reload cfg_idx stock to STOCK_INIT
// ---------------------------------------------------------------------------
module vend_slot_table
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = VEND_NUM_ITEMS,
    parameter int CREDIT_W   = VEND_CREDIT_W,
    parameter int STOCK_W    = VEND_STOCK_W,
    parameter int STOCK_INIT = VEND_STOCK_INIT,
    parameter int DEF_PRICE  = VEND_DEF_PRICE,
    parameter int IDX_W      = $clog2(NUM_ITEMS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [CREDIT_W-1:0] rd_price,
    output logic [STOCK_W-1:0]  rd_stock,
    input  logic                dec_en,
    input  logic [IDX_W-1:0]    dec_idx,
    input  logic                cfg_en,
    input  logic                cfg_we,
    input  logic                restock,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [CREDIT_W-1:0] cfg_price
);

    localparam logic [CREDIT_W-1:0] PRICE_RST = CREDIT_W'(DEF_PRICE);
    localparam logic [STOCK_W-1:0]  STOCK_RST = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0]  STOCK_ONE = {{(STOCK_W-1){1'b0}}, 1'b1};
    localparam logic [STOCK_W-1:0]  STOCK_NIL = {STOCK_W{1'b0}};
    localparam logic [CREDIT_W-1:0] PRICE_NIL = {CREDIT_W{1'b0}};

    logic [CREDIT_W-1:0] price_r [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock_r [NUM_ITEMS];

    assign rd_price = price_r[rd_idx];
    assign rd_stock = stock_r[rd_idx];

    // Price and stock storage with idle-only config and saturating decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                price_r[i] <= PRICE_RST;
                stock_r[i] <= STOCK_RST;
            end
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (cfg_en && cfg_we && (cfg_idx == IDX_W'(i)) && (cfg_price != PRICE_NIL)) begin
                    price_r[i] <= cfg_price;
                end
                if (cfg_en && restock && (cfg_idx == IDX_W'(i))) begin
                    stock_r[i] <= STOCK_RST;
                end else if (dec_en && (dec_idx == IDX_W'(i)) && (stock_r[i] != STOCK_NIL)) begin
                    stock_r[i] <= stock_r[i] - STOCK_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// ---------------------------------------------------------------------------
// vend_sequencer
// Sequences one vending sale: accumulate credit, judge a selection against
// the slot's price and stock, hold the dispense handshake, then pay change
// one coin per cycle. Every output is registered.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vend_sequencer_if.slave (coin, selection, cancel, config,
//              dispense handshake, change, credit, busy, status pulses)
// Within one CREDIT cycle cancel beats sel_valid beats coin; a coin that
// loses to cancel or a selection is returned, and the selection is judged
// on the credit held before that cycle's coin.
// ---------------------------------------------------------------------------
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = VEND_NUM_ITEMS,
    parameter int CREDIT_W   = VEND_CREDIT_W,
    parameter int STOCK_W    = VEND_STOCK_W,
    parameter int STOCK_INIT = VEND_STOCK_INIT,
    parameter int DEF_PRICE  = VEND_DEF_PRICE,
    parameter int TIMEOUT    = VEND_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    vend_sequencer_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_ITEMS);
    localparam int TMO_W = $clog2(TIMEOUT);

    localparam logic [CREDIT_W-1:0] CR_NIL   = {CREDIT_W{1'b0}};
    localparam logic [CREDIT_W-1:0] CR_ONE   = {{(CREDIT_W-1){1'b0}}, 1'b1};
    localparam logic [CREDIT_W-1:0] CR_TWO   = {{(CREDIT_W-2){1'b0}}, 2'b10};
    localparam logic [TMO_W-1:0]    TMO_NIL  = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0]    TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [STOCK_W-1:0]  STK_NIL  = {STOCK_W{1'b0}};

    state_e              state_r, state_nx;
    logic [CREDIT_W-1:0] credit_r, credit_nx;
    logic [TMO_W-1:0]    tmo_r, tmo_nx;
    logic                disp_req_r, disp_req_nx;
    logic [IDX_W-1:0]    disp_idx_r, disp_idx_nx;
    logic [1:0]          change_r, change_nx;
    logic                coin_reject_r, coin_reject_nx;
    logic                sold_out_r, sold_out_nx;
    logic                short_pay_r, short_pay_nx;
    logic                busy_r;

    logic [1:0]          coin_steps_s;
    logic                coin_any_s;
    logic                coin_valid_s;
    logic [CREDIT_W:0]   sum_s;
    logic [CREDIT_W-1:0] rd_price_s;
    logic [STOCK_W-1:0]  rd_stock_s;
    logic                dec_en_s;
    logic                cfg_en_s;

    assign coin_steps_s = coin_steps(bus.coin);
    assign coin_any_s   = (bus.coin != COIN_NONE);
    assign coin_valid_s = (bus.coin == COIN_5) || (bus.coin == COIN_10);
    // One extra bit so an overflowing coin can be detected and refused.
    assign sum_s        = {1'b0, credit_r} + {{(CREDIT_W-1){1'b0}}, coin_steps_s};
    assign cfg_en_s     = (state_r == ST_IDLE);

    vend_slot_table #(
        .NUM_ITEMS  (NUM_ITEMS),
        .CREDIT_W   (CREDIT_W),
        .STOCK_W    (STOCK_W),
        .STOCK_INIT (STOCK_INIT),
        .DEF_PRICE  (DEF_PRICE),
        .IDX_W      (IDX_W)
    ) u_slots (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (bus.sel_idx),
        .rd_price  (rd_price_s),
        .rd_stock  (rd_stock_s),
        .dec_en    (dec_en_s),
        .dec_idx   (bus.sel_idx),
        .cfg_en    (cfg_en_s),
        .cfg_we    (bus.cfg_we),
        .restock   (bus.restock),
        .cfg_idx   (bus.cfg_idx),
        .cfg_price (bus.cfg_price)
    );

    // Next-state and next-output decode for the sale sequence.
    always_comb begin
        state_nx       = state_r;
        credit_nx      = credit_r;
        tmo_nx         = tmo_r;
        disp_req_nx    = disp_req_r;
        disp_idx_nx    = disp_idx_r;
        change_nx      = CHG_NONE;
        coin_reject_nx = 1'b0;
        sold_out_nx    = 1'b0;
        short_pay_nx   = 1'b0;
        dec_en_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                tmo_nx = TMO_NIL;
                if (coin_valid_s) begin
                    credit_nx = {{(CREDIT_W-2){1'b0}}, coin_steps_s};
                    state_nx  = ST_CREDIT;
                end else if (bus.coin == COIN_BAD) begin
                    coin_reject_nx = 1'b1;
                end else begin
                    coin_reject_nx = 1'b0;
                end
                // Credit is always zero here, so any selection is short.
                if (bus.sel_valid && (credit_r == CR_NIL)) begin
                    short_pay_nx = 1'b1;
                end else begin
                    short_pay_nx = 1'b0;
                end
            end

            ST_CREDIT: begin
                if (bus.cancel) begin
                    state_nx       = ST_CHANGE;
                    tmo_nx         = TMO_NIL;
                    coin_reject_nx = coin_any_s;
                end else if (bus.sel_valid) begin
                    tmo_nx         = TMO_NIL;
                    coin_reject_nx = coin_any_s;
                    if (rd_stock_s == STK_NIL) begin
                        sold_out_nx = 1'b1;
                    end else if (credit_r < rd_price_s) begin
                        short_pay_nx = 1'b1;
                    end else begin
                        credit_nx   = credit_r - rd_price_s;
                        dec_en_s    = 1'b1;
                        disp_idx_nx = bus.sel_idx;
                        disp_req_nx = 1'b1;
                        state_nx    = ST_DISPENSE;
                    end
                end else if (coin_any_s) begin
                    tmo_nx = TMO_NIL;
                    if (!coin_valid_s || sum_s[CREDIT_W]) begin
                        coin_reject_nx = 1'b1;
                    end else begin
                        credit_nx = sum_s[CREDIT_W-1:0];
                    end
                end else if (tmo_r == TMO_LAST) begin
                    state_nx = ST_CHANGE;
                end else begin
                    tmo_nx = tmo_r + TMO_ONE;
                end
            end

            ST_DISPENSE: begin
                coin_reject_nx = coin_any_s;
                if (bus.disp_done) begin
                    disp_req_nx = 1'b0;
                    state_nx    = (credit_r != CR_NIL) ? ST_CHANGE : ST_IDLE;
                end else begin
                    disp_req_nx = 1'b1;
                end
            end

            ST_CHANGE: begin
                coin_reject_nx = coin_any_s;
                if (credit_r >= CR_TWO) begin
                    change_nx = CHG_10;
                    credit_nx = credit_r - CR_TWO;
                    state_nx  = (credit_r == CR_TWO) ? ST_IDLE : ST_CHANGE;
                end else if (credit_r == CR_ONE) begin
                    change_nx = CHG_5;
                    credit_nx = CR_NIL;
                    state_nx  = ST_IDLE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end

            default: begin
                state_nx    = ST_IDLE;
                credit_nx   = CR_NIL;
                disp_req_nx = 1'b0;
            end
        endcase
    end

    // State and registered-output update; reset drops the sale and its credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            credit_r      <= CR_NIL;
            tmo_r         <= TMO_NIL;
            disp_req_r    <= 1'b0;
            disp_idx_r    <= {IDX_W{1'b0}};
            change_r      <= CHG_NONE;
            coin_reject_r <= 1'b0;
            sold_out_r    <= 1'b0;
            short_pay_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nx;
            credit_r      <= credit_nx;
            tmo_r         <= tmo_nx;
            disp_req_r    <= disp_req_nx;
            disp_idx_r    <= disp_idx_nx;
            change_r      <= change_nx;
            coin_reject_r <= coin_reject_nx;
            sold_out_r    <= sold_out_nx;
            short_pay_r   <= short_pay_nx;
            busy_r        <= (state_nx != ST_IDLE);
        end
    end

    assign bus.disp_req    = disp_req_r;
    assign bus.disp_idx    = disp_idx_r;
    assign bus.change      = change_r;
    assign bus.credit      = credit_r;
    assign bus.busy        = busy_r;
    assign bus.coin_reject = coin_reject_r;
    assign bus.sold_out    = sold_out_r;
    assign bus.short_pay   = short_pay_r;

endmodule

// File: tb/tb_vend_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vend_sequencer
// Directed bench for vend_sequencer. Inputs change 1 time unit after a
// rising edge; outputs are checked at the same point, one edge after the
// input that causes them.
// ---------------------------------------------------------------------------
module tb_vend_sequencer;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    vend_sequencer_if #(.CREDIT_W(5), .IDX_W(2)) vif ();

    vend_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        vif.coin      = 2'b00;
        vif.sel_valid = 1'b0;
        vif.sel_idx   = 2'd0;
        vif.cancel    = 1'b0;
        vif.cfg_we    = 1'b0;
        vif.restock   = 1'b0;
        vif.cfg_idx   = 2'd0;
        vif.cfg_price = 5'd0;
        vif.disp_done = 1'b0;
    endtask

    task automatic put_coin(input logic [1:0] c);
        vif.coin = c;
        tick();
        vif.coin = 2'b00;
    endtask

    task automatic select(input logic [1:0] idx);
        vif.sel_valid = 1'b1;
        vif.sel_idx   = idx;
        tick();
        vif.sel_valid = 1'b0;
    endtask

    initial begin
        int waited;
        int paid;
        int pay_cycles;

        n_cmp = 0;
        n_bad = 0;
        clear_inputs();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_credit", int'(vif.credit), 0);
        check_eq("rst_busy", int'(vif.busy), 0);
        check_eq("rst_disp_req", int'(vif.disp_req), 0);
        check_eq("rst_disp_idx", int'(vif.disp_idx), 0);
        check_eq("rst_change", int'(vif.change), 0);
        check_eq("rst_price2", int'(dut.u_slots.price_r[2]), 3);

        // Exact pay: 10 + 5 = 3 steps, slot 0 costs 3
        put_coin(2'b10);
        check_eq("exact_credit_a", int'(vif.credit), 2);
        check_eq("exact_busy", int'(vif.busy), 1);
        put_coin(2'b01);
        check_eq("exact_credit_b", int'(vif.credit), 3);
        select(2'd0);
        check_eq("exact_disp_req", int'(vif.disp_req), 1);
        check_eq("exact_disp_idx", int'(vif.disp_idx), 0);
        check_eq("exact_credit_c", int'(vif.credit), 0);
        tick();
        check_eq("exact_req_held", int'(vif.disp_req), 1);
        vif.disp_done = 1'b1;
        tick();
        vif.disp_done = 1'b0;
        check_eq("exact_req_drop", int'(vif.disp_req), 0);
        check_eq("exact_idle", int'(vif.busy), 0);
        check_eq("exact_no_change", int'(vif.change), 0);
        check_eq("exact_stock0", int'(dut.u_slots.stock_r[0]), 7);

        // Overpay: 5 steps, slot 1 costs 3, change one 10-coin
        put_coin(2'b10);
        put_coin(2'b10);
        put_coin(2'b01);
        check_eq("over_credit", int'(vif.credit), 5);
        select(2'd1);
        check_eq("over_disp_idx", int'(vif.disp_idx), 1);
        check_eq("over_credit_left", int'(vif.credit), 2);
        vif.disp_done = 1'b1;
        tick();
        vif.disp_done = 1'b0;
        check_eq("over_req_drop", int'(vif.disp_req), 0);
        check_eq("over_busy_change", int'(vif.busy), 1);
        tick();
        check_eq("over_change10", int'(vif.change), 2);
        check_eq("over_credit_end", int'(vif.credit), 0);
        check_eq("over_idle", int'(vif.busy), 0);
        tick();
        check_eq("over_change_end", int'(vif.change), 0);

        // Cancel with 3 steps: 10 then 5
        put_coin(2'b10);
        put_coin(2'b01);
        vif.cancel = 1'b1;
        tick();
        vif.cancel = 1'b0;
        check_eq("cancel_credit", int'(vif.credit), 3);
        check_eq("cancel_change0", int'(vif.change), 0);
        tick();
        check_eq("cancel_change10", int'(vif.change), 2);
        check_eq("cancel_credit1", int'(vif.credit), 1);
        tick();
        check_eq("cancel_change5", int'(vif.change), 1);
        check_eq("cancel_idle", int'(vif.busy), 0);
        check_eq("cancel_no_disp", int'(vif.disp_req), 0);
        tick();
        check_eq("cancel_change_end", int'(vif.change), 0);

        // Coin together with a selection: coin returned, judged on old credit 1
        put_coin(2'b01);
        vif.coin = 2'b10;
        select(2'd3);
        vif.coin = 2'b00;
        check_eq("conf_short_pay", int'(vif.short_pay), 1);
        check_eq("conf_coin_reject", int'(vif.coin_reject), 1);
        check_eq("conf_credit", int'(vif.credit), 1);
        check_eq("conf_no_disp", int'(vif.disp_req), 0);
        tick();
        check_eq("conf_pulse_end", int'(vif.short_pay), 0);
        vif.cancel = 1'b1;
        tick();
        vif.cancel = 1'b0;
        tick();
        check_eq("conf_refund5", int'(vif.change), 1);

        // Timeout: credit 2, idle; CHANGE entered 64 edges after the coin
        put_coin(2'b10);
        repeat (60) tick();
        check_eq("tmo_still_credit", int'(vif.busy), 1);
        check_eq("tmo_no_change_yet", int'(vif.change), 0);
        waited = 0;
        while ((vif.change == 2'b00) && (waited < 20)) begin
            tick();
            waited++;
        end
        check_eq("tmo_wait_cycles", waited, 5);
        check_eq("tmo_change10", int'(vif.change), 2);
        check_eq("tmo_idle", int'(vif.busy), 0);
        check_eq("tmo_credit0", int'(vif.credit), 0);

        // Credit ceiling: 31 steps max, overflowing coins refused
        for (int i = 0; i < 15; i++) put_coin(2'b10);
        check_eq("ovf_credit30", int'(vif.credit), 30);
        put_coin(2'b10);
        check_eq("ovf_reject10", int'(vif.coin_reject), 1);
        check_eq("ovf_credit_kept", int'(vif.credit), 30);
        put_coin(2'b01);
        check_eq("ovf_accept5", int'(vif.coin_reject), 0);
        check_eq("ovf_credit31", int'(vif.credit), 31);
        put_coin(2'b01);
        check_eq("ovf_reject5", int'(vif.coin_reject), 1);
        vif.cfg_we    = 1'b1;
        vif.cfg_idx   = 2'd0;
        vif.cfg_price = 5'd1;
        tick();
        vif.cfg_we = 1'b0;
        check_eq("busy_cfg_ignored", int'(dut.u_slots.price_r[0]), 3);
        vif.cancel = 1'b1;
        tick();
        vif.cancel = 1'b0;
        paid = 0;
        pay_cycles = 0;
        while ((vif.busy == 1'b1) && (pay_cycles < 40)) begin
            tick();
            pay_cycles++;
            paid += int'(vif.change);
        end
        check_eq("ovf_paid_steps", paid, 31);
        check_eq("ovf_pay_cycles", pay_cycles, 16);

        // Config price 0 ignored, then price 1 on slot 2; drain its stock
        vif.cfg_we    = 1'b1;
        vif.cfg_idx   = 2'd2;
        vif.cfg_price = 5'd0;
        tick();
        check_eq("cfg_zero_ignored", int'(dut.u_slots.price_r[2]), 3);
        vif.cfg_price = 5'd1;
        tick();
        vif.cfg_we = 1'b0;
        check_eq("cfg_price2", int'(dut.u_slots.price_r[2]), 1);
        for (int i = 0; i < 8; i++) begin
            put_coin(2'b01);
            select(2'd2);
            check_eq($sformatf("buy%0d_disp", i), int'(vif.disp_req), 1);
            vif.disp_done = 1'b1;
            tick();
            vif.disp_done = 1'b0;
            check_eq($sformatf("buy%0d_idle", i), int'(vif.busy), 0);
        end
        check_eq("stock2_empty", int'(dut.u_slots.stock_r[2]), 0);
        put_coin(2'b01);
        select(2'd2);
        check_eq("sold_out_pulse", int'(vif.sold_out), 1);
        check_eq("sold_out_credit", int'(vif.credit), 1);
        check_eq("sold_out_no_short", int'(vif.short_pay), 0);
        check_eq("sold_out_no_disp", int'(vif.disp_req), 0);
        tick();
        check_eq("sold_out_end", int'(vif.sold_out), 0);
        vif.cancel = 1'b1;
        tick();
        vif.cancel = 1'b0;
        tick();
        check_eq("sold_out_refund", int'(vif.change), 1);
        put_coin(2'b11);
        check_eq("idle_bad_coin", int'(vif.coin_reject), 1);
        check_eq("idle_bad_busy", int'(vif.busy), 0);
        tick();
        check_eq("idle_bad_end", int'(vif.coin_reject), 0);
        select(2'd1);
        check_eq("idle_short_pay", int'(vif.short_pay), 1);
        vif.restock = 1'b1;
        vif.cfg_idx = 2'd2;
        tick();
        vif.restock = 1'b0;
        check_eq("restock2", int'(dut.u_slots.stock_r[2]), 8);

        // Reset in the middle of a dispense
        put_coin(2'b10);
        put_coin(2'b01);
        select(2'd0);
        check_eq("rstmid_disp_req", int'(vif.disp_req), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstmid_req_drop", int'(vif.disp_req), 0);
        check_eq("rstmid_credit", int'(vif.credit), 0);
        check_eq("rstmid_busy", int'(vif.busy), 0);
        check_eq("rstmid_change", int'(vif.change), 0);
        check_eq("rstmid_price2", int'(dut.u_slots.price_r[2]), 3);
        check_eq("rstmid_stock0", int'(dut.u_slots.stock_r[0]), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
